fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: fetches bytes from memory, assembles little-endian 16-bit ops
// and queues them with their PC in a small FIFO for the consumer.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [15:0]       op_data,
  output logic [ADDR_W-1:0] op_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t state;
  logic [ADDR_W-1:0] fetch_pc, addr, target, next_pc;
  logic [7:0] low;
  logic discard, push, pop, room;
  logic [PW-1:0] wr, rd;
  logic [PW:0] count, count_after;
  logic [15:0] buf_data [DEPTH];
  logic [ADDR_W-1:0] buf_pc [DEPTH];
  assign target = redirect_pc & ~ADDR_W'(1);
  assign next_pc = fetch_pc + ADDR_W'(2);
  assign push = state == HI && mem_ack && !discard && !redirect;
  assign pop = op_valid && op_ready;
  assign count_after = count + (PW+1)'(push) - (PW+1)'(pop);
  assign room = count_after < FULL;
  assign mem_req = state != IDLE;
  assign mem_addr = addr;
  assign op_valid = count != '0;
  assign op_data = op_valid ? buf_data[rd] : '0;
  assign op_pc = op_valid ? buf_pc[rd] : '0;
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr] <= {mem_rdata, low};
      buf_pc[wr] <= fetch_pc;
    end
  end
  // a redirect during an unacked request keeps the bus request alive and drops its data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      addr <= RESET_PC;
      low <= '0;
      discard <= 1'b0;
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (redirect) begin
        wr <= '0;
        rd <= '0;
        count <= '0;
        low <= '0;
        fetch_pc <= target;
        if (state != IDLE && !mem_ack) discard <= 1'b1;
        else begin
          discard <= 1'b0;
          state <= LO;
          addr <= target;
        end
      end else begin
        wr <= wr + PW'(push);
        rd <= rd + PW'(pop);
        count <= count_after;
        case (state)
          IDLE: if (room) begin
            state <= LO;
            addr <= fetch_pc;
          end
          LO: if (mem_ack) begin
            if (discard) begin
              discard <= 1'b0;
              addr <= fetch_pc;
            end else begin
              low <= mem_rdata;
              state <= HI;
              addr <= fetch_pc | ADDR_W'(1);
            end
          end
          HI: if (mem_ack) begin
            if (discard) begin
              discard <= 1'b0;
              state <= LO;
              addr <= fetch_pc;
            end else begin
              fetch_pc <= next_pc;
              addr <= next_pc;
              state <= room ? LO : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and directed checks plus a randomized run
// scored against an op-stream model of memory contents.
module tb_fetch_unit;
  localparam int AW = 16;
  localparam logic [15:0] RPC = 16'h0000;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0, redirect = 0, mem_ack = 0, op_ready = 0;
  logic [15:0] redirect_pc = 0, mem_addr, op_data, op_pc;
  logic [7:0] mem_rdata = 0;
  logic mem_req, op_valid;
  fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_pc(op_pc)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [7:0] mem [65536];
  int fixed_delay = 0, wait_cnt = 0, cur_delay = 0, pops = 0;
  bit rand_delay = 0, idle_ack = 0, pend_prev = 0, hold_prev = 0;
  logic [15:0] exp_pc = RPC, addr_prev, data_prev, pc_prev;
  logic [15:0] pop_log [$];
  typedef struct {
    bit ready;
    bit exp_req;
    logic [15:0] exp_addr;
    bit exp_valid;
    logic [15:0] exp_data;
    logic [15:0] exp_pc;
  } vec_t;
  vec_t tbl [7];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] op_at(logic [15:0] pc);
    return {mem[pc + 16'd1], mem[pc]};
  endfunction

  // memory responder plus scoreboard; outputs are stable at the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      wait_cnt = 0;
      mem_ack = idle_ack;
      exp_pc = RPC;
      pend_prev = 0;
      hold_prev = 0;
    end else begin
      if (mem_req) begin
        if (wait_cnt == 0) cur_delay = rand_delay ? int'($urandom_range(2, 0)) : fixed_delay;
        if (wait_cnt >= cur_delay) begin
          mem_ack = 1;
          mem_rdata = mem[mem_addr];
          wait_cnt = 0;
        end else begin
          mem_ack = 0;
          mem_rdata = 8'($urandom);
          wait_cnt++;
        end
      end else begin
        mem_ack = idle_ack;
        mem_rdata = 8'($urandom);
      end
      if (pend_prev) check("addr_stable", mem_addr, addr_prev);
      if (hold_prev) check("op_stable", {op_data, op_pc}, {data_prev, pc_prev});
      if (op_valid && op_ready) begin
        check("pop_pc", op_pc, exp_pc);
        check("pop_data", op_data, op_at(exp_pc));
        pop_log.push_back(op_pc);
        pops++;
        exp_pc = exp_pc + 16'd2;
      end
      if (redirect) exp_pc = {redirect_pc[15:1], 1'b0};
      pend_prev = mem_req && !mem_ack;
      addr_prev = mem_addr;
      hold_prev = op_valid && !op_ready && !redirect;
      data_prev = op_data;
      pc_prev = op_pc;
    end
  end

  task automatic do_reset();
    rst_n = 0;
    idle_ack = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    idle_ack = 0;
  endtask

  task automatic wait_log(int n, int bound, string name);
    int k = 0;
    while (pop_log.size() < n && k < bound) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (pop_log.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout, got %0d ops expected %0d", name, pop_log.size(), n);
    end
  endtask

  task automatic check_reset_outputs(string name);
    check({name, "_req"}, mem_req, 0);
    check({name, "_valid"}, op_valid, 0);
    check({name, "_addr"}, mem_addr, RPC);
    check({name, "_data"}, op_data, 0);
    check({name, "_pc"}, op_pc, 0);
  endtask

  initial begin
    int n;
    logic [15:0] held;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h08; mem[1] = 8'h81; mem[2] = 8'h64; mem[3] = 8'h82;
    tbl[0] = '{1, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    tbl[1] = '{1, 1, 16'h0000, 0, 16'h0000, 16'h0000};
    tbl[2] = '{1, 1, 16'h0001, 0, 16'h0000, 16'h0000};
    tbl[3] = '{1, 1, 16'h0002, 1, 16'h8108, 16'h0000};
    tbl[4] = '{1, 1, 16'h0003, 0, 16'h0000, 16'h0000};
    tbl[5] = '{1, 1, 16'h0004, 1, 16'h8264, 16'h0002};
    tbl[6] = '{1, 1, 16'h0005, 0, 16'h0000, 16'h0000};
    idle_ack = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    idle_ack = 0;
    for (int i = 0; i < 7; i++) begin
      op_ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("tbl%0d_req", i), mem_req, tbl[i].exp_req);
      check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), op_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_data", i), op_data, tbl[i].exp_data);
        check($sformatf("tbl%0d_pc", i), op_pc, tbl[i].exp_pc);
      end
      @(posedge clk);
      #1;
    end
    // backpressure: buffer fills to DEPTH, fetch stalls, then drains in order
    op_ready = 0;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check("full_req", mem_req, 0);
    check("full_valid", op_valid, 1);
    check("full_head", {op_data, op_pc}, {16'h8108, 16'h0000});
    pop_log.delete();
    op_ready = 1;
    @(negedge clk);
    n = 0;
    while (op_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("drain_run", n, DEPTH);
    wait_log(3, 40, "drain_log");
    if (pop_log.size() >= 3) check("drain_order", {pop_log[0], pop_log[1], pop_log[2]}, {16'h0, 16'h2, 16'h4});
    // slow memory
    op_ready = 0;
    fixed_delay = 3;
    do_reset();
    n = 0;
    while (!mem_req && n < 10) begin @(posedge clk); #1; n++; end
    n = 0;
    while (!op_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("slow_latency", n, 8);
    check("slow_data", op_data, 16'h8108);
    // redirect while the high byte is outstanding
    n = 0;
    while (!(mem_req && mem_addr[0]) && n < 40) begin @(posedge clk); #1; n++; end
    fixed_delay = 6;
    check("pre_redir_valid", op_valid, 1);
    held = mem_addr;
    redirect = 1;
    redirect_pc = 16'h0011;
    @(posedge clk);
    #1;
    redirect = 0;
    check("redir_flush", op_valid, 0);
    check("redir_hold_req", mem_req, 1);
    check("redir_hold_addr", mem_addr, held);
    fixed_delay = 0;
    pop_log.delete();
    op_ready = 1;
    wait_log(1, 60, "redir_log");
    if (pop_log.size() >= 1) check("redir_first_pc", pop_log[0], 16'h0010);
    // wrap at top of address space
    op_ready = 0;
    redirect = 1;
    redirect_pc = 16'hFFFE;
    @(posedge clk);
    #1;
    redirect = 0;
    pop_log.delete();
    op_ready = 1;
    wait_log(2, 40, "wrap_log");
    if (pop_log.size() >= 2) check("wrap_pcs", {pop_log[0], pop_log[1]}, {16'hFFFE, 16'h0000});
    // back-to-back redirects: last target wins
    op_ready = 0;
    foreach (tbl[i]) if (i < 3) begin
      redirect = 1;
      redirect_pc = (i == 0) ? 16'h0100 : (i == 1) ? 16'h0200 : 16'h0301;
      @(posedge clk);
      #1;
    end
    redirect = 0;
    pop_log.delete();
    op_ready = 1;
    wait_log(1, 40, "multi_redir_log");
    if (pop_log.size() >= 1) check("multi_redir_pc", pop_log[0], 16'h0300);
    // asynchronous reset in the middle of fetching, with ack held high
    @(posedge clk);
    #3;
    idle_ack = 1;
    rst_n = 0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    rst_n = 1;
    idle_ack = 0;
    pop_log.delete();
    @(posedge clk);
    #1;
    check("restart_req", mem_req, 1);
    check("restart_addr", mem_addr, RPC);
    wait_log(1, 40, "restart_log");
    if (pop_log.size() >= 1) check("restart_pc", pop_log[0], RPC);
    // randomized traffic against the scoreboard
    rand_delay = 1;
    n = pops;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      op_ready = $urandom_range(3, 0) != 0;
      redirect = $urandom_range(40, 0) == 0;
      redirect_pc = 16'($urandom);
    end
    redirect = 0;
    check("random_progress", pops - n > 100, 1);
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
